mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Load/store front-end that sits directly upstream of Memoria32 (32-bit word memory: raddress, waddress, Datain, Dataout, Wr).
- Accepts one byte/halfword/word request at a time from the datapath and translates it into word-aligned memory accesses.
- Performs read-modify-write for sub-word stores, and lane extraction with sign/zero extension for loads.
- Returns one response per request; at most one request is in flight.

Parameters:
- RAM_BYTES, 4096, addressable memory size in bytes; used only by the optional bounds check.
- MEM_RD_LAT, 1, cycles from a mem_raddress change to valid mem_rdata; legal range 1..3.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and is treated as misaligned.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal request.
- mem_raddress  out  32  to Memoria32 raddress; word-aligned, bits[1:0] = 0.
- mem_waddress  out  32  to Memoria32 waddress; word-aligned.
- mem_wdata  out  32  to Memoria32 Datain.
- mem_wr  out  1  to Memoria32 Wr.
- mem_rdata  in  32  from Memoria32 Dataout.

Behaviour:
- Reset values (asynchronous, take effect immediately): state IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mem_* = 0, mem_wr = 0.
- Reset mid-operation: the pending operation is dropped, no response is produced, and mem_wr drops immediately.
- FSM states: IDLE, RD_WAIT, WRITE, RESP. req_ready = 1 only in IDLE.
- Acceptance: a request is accepted on the clock edge where req_valid && req_ready. All request fields are registered at that edge.
- Alignment check: half requires addr[0] = 0; word requires addr[1:0] = 0; size 3 always fails.
  - On failure: go to RESP with rsp_err = 1 and rsp_rdata = 0. No memory access is made. Latency is 1 cycle.
- Word store: IDLE -> WRITE with mem_waddress = {addr[31:2], 2'b00}, mem_wdata = wdata, mem_wr = 1 for exactly one cycle. Then RESP. rsp_valid is high 2 edges after acceptance.
- Load: IDLE -> RD_WAIT with mem_raddress set to the word address and a counter loaded with MEM_RD_LAT.
  - When the counter expires, mem_rdata is captured and formatted, and the FSM goes to RESP.
  - rsp_valid is high MEM_RD_LAT+1 edges after acceptance.
- Load formatting (little-endian):
  - Byte lane = addr[1:0]; half lane = addr[1].
  - The selected lane is extended to 32 bits: signed when req_unsigned = 0, zero-extended otherwise.
- Sub-word store: RD_WAIT (as for a load), then WRITE.
  - The written word is the old word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - rsp_valid is high MEM_RD_LAT+2 edges after acceptance.
- RESP: rsp_valid stays 1 and rsp_rdata/rsp_err stay stable until rsp_ready. On the handshake edge the FSM returns to IDLE; the next request can be accepted on the following edge.
- mem_wr is 1 only in WRITE and never for two consecutive cycles. mem_raddress holds its value outside RD_WAIT.
- Address width: bits above RAM_BYTES are passed through unchanged; Memoria32 wraps internally.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined: a request with addr >= RAM_BYTES is treated like a misaligned request (rsp_err = 1, no memory access, latency 1). If both misaligned and out of range, rsp_err = 1 once.
- Undefined: no range check; all aligned requests access memory.

Decomposition:
- Shared package mem_pkg:
  - mem_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - ctrl_state_t enum.
  - WORD_W = 32.
- Sub-module mem_lane_fmt (combinational):
  - Load extract/extend: (word, addr[1:0], size, unsigned) -> result.
  - Store merge: (old word, wdata, addr[1:0], size) -> new word.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> store response after 2 edges; load rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Byte store 0x7F @0x13 over 0x11223344 -> memory word becomes 0x7F223344; exactly one mem_wr pulse. Signed byte load @0x13 = 0x0000007F. Byte store 0x80 @0x13, then signed load -> 0xFFFFFF80; unsigned load -> 0x00000080.
- Half load @0x12 of word 0x8001ABCD -> signed 0xFFFF8001, unsigned 0x00008001.
- Half load @0x11 and word store @0x06 -> rsp_err = 1, rsp_rdata = 0, mem_wr never asserted, memory unchanged.
- rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0; next request accepted on the edge after the handshake.
- nrst pulsed low during RD_WAIT of a byte store -> outputs return to reset values immediately, no mem_wr, no response. With MEM_BOUNDS_CHECK_EN defined: load @0x1000 -> rsp_err = 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the load/store front-end: access sizes, controller states
// and the alignment rule used at request acceptance.
package mem_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_RESP    = 2'd3
   } ctrl_state_t;

   // Size encoding 3 is not a legal access and is reported like a misalignment.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = |lane;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Little-endian lane handling: load extraction with sign/zero extension and
// sub-word store merge into the previously read word.
module mem_lane_fmt
   import mem_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [1:0]        i_lane,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   output logic [WORD_W-1:0] o_load,
   output logic [WORD_W-1:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sign;

   assign w_byte = i_word[{i_lane, 3'b000} +: 8];
   assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_load = i_word;
      w_sign = 1'b0;
      case (i_size)
         SZ_BYTE: begin
            w_sign = ~i_unsigned & w_byte[7];
            o_load = {{24{w_sign}}, w_byte};
         end
         SZ_HALF: begin
            w_sign = ~i_unsigned & w_half[15];
            o_load = {{16{w_sign}}, w_half};
         end
         default: o_load = i_word;
      endcase
   end

   always_comb begin
      o_merged = i_word;
      case (i_size)
         SZ_BYTE: o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
         SZ_HALF: begin
            if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
            else           o_merged[15:0]  = i_wdata[15:0];
         end
         default: o_merged = i_wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front-end for Memoria32: one request in flight, RMW for sub-word
// stores. Optional range check enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned RAM_BYTES  = 4096,
   parameter int unsigned MEM_RD_LAT = 1
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_raddress,
   output logic [31:0] mem_waddress,
   output logic [31:0] mem_wdata,
   output logic        mem_wr,
   input  logic [31:0] mem_rdata
);

   if (MEM_RD_LAT < 1 || MEM_RD_LAT > 3) begin : g_bad_lat
      $error("mem_access_ctrl: MEM_RD_LAT must be in 1..3");
   end
   if (RAM_BYTES < 4 || (RAM_BYTES % 4) != 0) begin : g_bad_ram
      $error("mem_access_ctrl: RAM_BYTES must be a non-zero multiple of 4");
   end

   localparam logic [1:0] RD_LAT = 2'(MEM_RD_LAT);

   ctrl_state_t       r_state;
   logic              r_store;
   logic              r_unsigned;
   logic [1:0]        r_size;
   logic [1:0]        r_lane;
   logic [31:0]       r_wdata;
   logic [1:0]        r_cnt;
   logic [31:0]       r_rsp_rdata;
   logic              r_rsp_err;
   logic [31:0]       r_mem_raddr;
   logic [31:0]       r_mem_waddr;
   logic [31:0]       r_mem_wdata;
   logic              r_mem_wr;

   logic              w_oob;
   logic              w_bad;
   logic [31:0]       w_word_addr;
   logic [WORD_W-1:0] w_load;
   logic [WORD_W-1:0] w_merged;

`ifdef MEM_BOUNDS_CHECK_EN
   assign w_oob = (req_addr >= RAM_BYTES);
`else
   assign w_oob = 1'b0;
`endif

   assign w_bad       = misaligned(req_size, req_addr[1:0]) | w_oob;
   assign w_word_addr = {req_addr[31:2], 2'b00};

   mem_lane_fmt u_lane_fmt (
      .i_word     (mem_rdata),
      .i_wdata    (r_wdata),
      .i_lane     (r_lane),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_load     (w_load),
      .o_merged   (w_merged)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state     <= ST_IDLE;
         r_store     <= 1'b0;
         r_unsigned  <= 1'b0;
         r_size      <= '0;
         r_lane      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_mem_raddr <= '0;
         r_mem_waddr <= '0;
         r_mem_wdata <= '0;
         r_mem_wr    <= 1'b0;
      end else begin
         r_mem_wr <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_store    <= req_store;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_lane     <= req_addr[1:0];
                  r_wdata    <= req_wdata;
                  if (w_bad) begin
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                     r_state     <= ST_RESP;
                  end else if (req_store && req_size == SZ_WORD) begin
                     r_mem_waddr <= w_word_addr;
                     r_mem_wdata <= req_wdata;
                     r_mem_wr    <= 1'b1;
                     r_state     <= ST_WRITE;
                  end else begin
                     // Loads and sub-word stores both start with a word read.
                     r_mem_raddr <= w_word_addr;
                     r_cnt       <= RD_LAT;
                     r_state     <= ST_RD_WAIT;
                  end
               end
            end
            ST_RD_WAIT: begin
               if (r_cnt == 2'd1) begin
                  if (r_store) begin
                     r_mem_waddr <= r_mem_raddr;
                     r_mem_wdata <= w_merged;
                     r_mem_wr    <= 1'b1;
                     r_state     <= ST_WRITE;
                  end else begin
                     r_rsp_rdata <= w_load;
                     r_rsp_err   <= 1'b0;
                     r_state     <= ST_RESP;
                  end
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
            ST_WRITE: begin
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready    = (r_state == ST_IDLE);
   assign rsp_valid    = (r_state == ST_RESP);
   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_err      = r_rsp_err;
   assign mem_raddress = r_mem_raddr;
   assign mem_waddress = r_mem_waddr;
   assign mem_wdata    = r_mem_wdata;
   assign mem_wr       = r_mem_wr;

endmodule
